// File: rtl/scariv_regread_stage_pkg.sv
// Shared types and sizing for the register-read stage: register class, stage states,
// and the width / rename-id helpers used by the stage and its operand slices.
package scariv_regread_stage_pkg;

   typedef enum logic {GPR, FPR} reg_type_t;
   typedef enum logic [1:0] {RR_IDLE, RR_WAIT, RR_FULL} rr_state_t;

   localparam int XLEN_W        = 64;
   localparam int FLEN_W        = 64;
   localparam int XPR_RNID_SIZE = 64;
   localparam int FPR_RNID_SIZE = 64;

   function automatic int rr_width(input reg_type_t t);
      return (t == GPR) ? XLEN_W : FLEN_W;
   endfunction

   function automatic int rr_rnid_w(input reg_type_t t);
      return $clog2((t == GPR) ? XPR_RNID_SIZE : FPR_RNID_SIZE);
   endfunction

endpackage

// File: rtl/scariv_regread_operand.sv
// One source-operand slice: capture mux at accept, writeback snoop while pending,
// pending flag and held data register.
module scariv_regread_operand
   import scariv_regread_stage_pkg::*;
#(
   parameter reg_type_t REG_TYPE     = GPR,
   parameter int        WR_PORT_SIZE = 5,
   parameter int        WIDTH        = 64,
   parameter int        RNID_W       = 6
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset_n,
   input  logic                                 i_flush,
   input  logic                                 i_load,
   input  logic                                 i_used,
   input  logic                                 i_ready,
   input  logic [RNID_W-1:0]                    i_rnid,
   input  logic [WIDTH-1:0]                     i_rd_data,
   input  logic [WR_PORT_SIZE-1:0]              i_wr_valid,
   input  logic [WR_PORT_SIZE-1:0][RNID_W-1:0]  i_wr_rnid,
   input  logic [WR_PORT_SIZE-1:0][WIDTH-1:0]   i_wr_data,
   output logic                                 o_pending,
   output logic                                 o_pend_nxt,
   output logic [WIDTH-1:0]                     o_data
);

   logic              r_pending;
   logic [RNID_W-1:0] r_rnid;
   logic [WIDTH-1:0]  r_data;

   logic [RNID_W-1:0] w_cmp_rnid;
   logic              w_is_zero;
   logic              w_hit;
   logic [WIDTH-1:0]  w_hit_data;
   logic              w_pend_nxt;
   logic [WIDTH-1:0]  w_data_nxt;

   // One snoop comparator serves both the accept-cycle bypass and the pending wait.
   assign w_cmp_rnid = i_load ? i_rnid : r_rnid;
   assign w_is_zero  = (REG_TYPE == GPR) && (i_rnid == '0);

   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      // Descending scan so the lowest matching port is the last (winning) assignment.
      for (int p = WR_PORT_SIZE - 1; p >= 0; p--) begin
         if (i_wr_valid[p] && (i_wr_rnid[p] == w_cmp_rnid) &&
             !((REG_TYPE == GPR) && (w_cmp_rnid == '0))) begin
            w_hit      = 1'b1;
            w_hit_data = i_wr_data[p];
         end
      end
   end

   always_comb begin
      w_pend_nxt = r_pending;
      w_data_nxt = r_data;
      if (i_flush) begin
         w_pend_nxt = 1'b0;
      end else if (i_load) begin
         w_pend_nxt = 1'b0;
         if (!i_used || w_is_zero) w_data_nxt = '0;
         else if (w_hit)           w_data_nxt = w_hit_data;
         else if (i_ready)         w_data_nxt = i_rd_data;
         else                      w_pend_nxt = 1'b1;
      end else if (r_pending && w_hit) begin
         w_pend_nxt = 1'b0;
         w_data_nxt = w_hit_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pending <= 1'b0;
         r_rnid    <= '0;
         r_data    <= '0;
      end else begin
         r_pending <= w_pend_nxt;
         r_data    <= w_data_nxt;
         if (i_load) r_rnid <= i_rnid;
      end
   end

   assign o_pending  = r_pending;
   assign o_pend_nxt = w_pend_nxt;
   assign o_data     = r_data;

endmodule

// File: rtl/scariv_regread_stage.sv
// One-entry register-read stage: accepts an issued op, reads/bypasses/snoops both sources,
// and hands a complete operand pair to execute over a valid/ready handshake.
module scariv_regread_stage
   import scariv_regread_stage_pkg::*;
#(
   parameter reg_type_t REG_TYPE     = GPR,
   parameter int        WR_PORT_SIZE = 5,
   parameter int        TAG_W        = 8,
   localparam int       WIDTH        = rr_width(REG_TYPE),
   localparam int       RNID_W       = rr_rnid_w(REG_TYPE)
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset_n,
   input  logic                                 i_flush,
   input  logic                                 i_valid,
   output logic                                 o_ready,
   input  logic [TAG_W-1:0]                     i_tag,
   input  logic [1:0]                           i_rs_used,
   input  logic [1:0]                           i_rs_ready,
   input  logic [1:0][RNID_W-1:0]               i_rs_rnid,
   output logic [1:0]                           o_rd_valid,
   output logic [1:0][RNID_W-1:0]               o_rd_rnid,
   input  logic [1:0]                           i_rd_resp,
   input  logic [1:0][WIDTH-1:0]                i_rd_data,
   input  logic [WR_PORT_SIZE-1:0]              i_wr_valid,
   input  logic [WR_PORT_SIZE-1:0][RNID_W-1:0]  i_wr_rnid,
   input  logic [WR_PORT_SIZE-1:0][WIDTH-1:0]   i_wr_data,
   output logic                                 o_out_valid,
   input  logic                                 i_out_ready,
   output logic [TAG_W-1:0]                     o_out_tag,
   output logic [1:0][WIDTH-1:0]                o_out_data,
   output rr_state_t                            o_dbg_state
);

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // ready never depends on the partner's valid in the same cycle.
   rr_state_t        r_state;
   logic [TAG_W-1:0] r_tag;
   logic             w_accept;
   logic [1:0]       w_pending;
   logic [1:0]       w_pend_nxt;

   assign o_ready  = !i_flush && ((r_state == RR_IDLE) || ((r_state == RR_FULL) && i_out_ready));
   assign w_accept = i_valid && o_ready;

   for (genvar k = 0; k < 2; k++) begin : g_src
      assign o_rd_valid[k] = w_accept && i_rs_used[k] && i_rs_ready[k];
      assign o_rd_rnid[k]  = o_rd_valid[k] ? i_rs_rnid[k] : '0;

      scariv_regread_operand #(
         .REG_TYPE     (REG_TYPE),
         .WR_PORT_SIZE (WR_PORT_SIZE),
         .WIDTH        (WIDTH),
         .RNID_W       (RNID_W)
      ) u_operand (
         .i_clk      (i_clk),
         .i_reset_n  (i_reset_n),
         .i_flush    (i_flush),
         .i_load     (w_accept),
         .i_used     (i_rs_used[k]),
         .i_ready    (i_rs_ready[k]),
         .i_rnid     (i_rs_rnid[k]),
         .i_rd_data  (i_rd_data[k]),
         .i_wr_valid (i_wr_valid),
         .i_wr_rnid  (i_wr_rnid),
         .i_wr_data  (i_wr_data),
         .o_pending  (w_pending[k]),
         .o_pend_nxt (w_pend_nxt[k]),
         .o_data     (o_out_data[k])
      );
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= RR_IDLE;
         r_tag   <= '0;
      end else if (i_flush) begin
         r_state <= RR_IDLE;
      end else begin
         if (w_accept) r_tag <= i_tag;
         case (r_state)
            RR_IDLE: if (w_accept) r_state <= (|w_pend_nxt) ? RR_WAIT : RR_FULL;
            RR_WAIT: if (!(|w_pend_nxt)) r_state <= RR_FULL;
            RR_FULL: begin
               if (w_accept)         r_state <= (|w_pend_nxt) ? RR_WAIT : RR_FULL;
               else if (i_out_ready) r_state <= RR_IDLE;
            end
            default: r_state <= RR_IDLE;
         endcase
      end
   end

   assign o_out_valid = (r_state == RR_FULL);
   assign o_out_tag   = r_tag;
   assign o_dbg_state = r_state;

`ifndef SYNTHESIS
   a_resp_matches_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (i_rd_resp == o_rd_valid) && ((r_state == RR_WAIT) == (|w_pending)));
`endif

endmodule

// File: tb/tb_scariv_regread_stage.sv
// Bench for scariv_regread_stage: directed scenarios plus a randomized run against
// a transaction-level model with its own register file.
module tb_scariv_regread_stage;
   import scariv_regread_stage_pkg::*;

   logic clk, rst_n, flush, valid, o_ready, out_valid, out_ready;
   logic [7:0] tag, out_tag;
   logic [1:0] used, rdy, rd_valid, rd_resp;
   logic [1:0][5:0] rnid, rd_rnid;
   logic [1:0][63:0] rd_data, out_data;
   logic [4:0] wr_valid;
   logic [4:0][5:0] wr_rnid;
   logic [4:0][63:0] wr_data;
   rr_state_t dbg_state;

   logic [63:0] rf [64];
   int n_vec = 0, n_err = 0;

   scariv_regread_stage dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
      .i_tag(tag), .i_rs_used(used), .i_rs_ready(rdy), .i_rs_rnid(rnid),
      .o_rd_valid(rd_valid), .o_rd_rnid(rd_rnid), .i_rd_resp(rd_resp), .i_rd_data(rd_data),
      .i_wr_valid(wr_valid), .i_wr_rnid(wr_rnid), .i_wr_data(wr_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_tag(out_tag),
      .o_out_data(out_data), .o_dbg_state(dbg_state)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Register file: writes land at the edge, so a same-cycle read sees the old value.
   always @(posedge clk)
      for (int p = 4; p >= 0; p--)
         if (wr_valid[p] && wr_rnid[p] != 0) rf[wr_rnid[p]] <= wr_data[p];

   always_comb begin
      rd_resp = rd_valid;
      for (int k = 0; k < 2; k++) rd_data[k] = rf[rd_rnid[k]];
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      flush = 0; valid = 0; tag = 0; used = 0; rdy = 0; rnid = '0;
      wr_valid = 0; wr_rnid = '0; wr_data = '0; out_ready = 0;
   endtask

   task automatic issue(input logic [7:0] t, input logic [1:0] u, input logic [1:0] r,
                        input logic [5:0] r0, input logic [5:0] r1);
      valid = 1; tag = t; used = u; rdy = r; rnid[0] = r0; rnid[1] = r1;
   endtask

   task automatic test_reset();
      idle_inputs();
      for (int i = 0; i < 64; i++) rf[i] = 64'(i) * 64'h101;
      rf[0] = 0;
      rst_n = 0;
      #12;
      n_vec++; if (out_valid !== 1'b0 || out_tag !== 8'h0 || out_data !== '0 || rd_valid !== 2'b00) begin
         n_err++; $display("FAIL reset_outputs: valid=%b tag=%h data=%h rdv=%b, wanted all zero", out_valid, out_tag, out_data, rd_valid);
      end
      rst_n = 1;
      tick();
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
   endtask

   task automatic test_basic();
      rf[5] = 64'h11;
      issue(8'h01, 2'b11, 2'b11, 6'd5, 6'd0);
      #1;
      n_vec++; if (rd_valid !== 2'b11 || rd_rnid[0] !== 6'd5) begin
         n_err++; $display("FAIL t1_readport: rdv=%b rnid0=%0d want 11/5", rd_valid, rd_rnid[0]);
      end
      tick(); idle_inputs();
      n_vec++; if (out_valid !== 1'b1 || out_data[0] !== 64'h11 || out_data[1] !== 64'h0 || out_tag !== 8'h01) begin
         n_err++; $display("FAIL t1_out: v=%b d0=%h d1=%h tag=%h want 1/11/0/01", out_valid, out_data[0], out_data[1], out_tag);
      end
      out_ready = 1; tick(); out_ready = 0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_bypass();
      rf[7] = 64'h77;
      issue(8'h02, 2'b01, 2'b01, 6'd7, 6'd0);
      wr_valid[3] = 1; wr_rnid[3] = 6'd7; wr_data[3] = 64'hAA;
      tick(); idle_inputs();
      n_vec++; if (out_valid !== 1'b1 || out_data[0] !== 64'hAA) begin
         n_err++; $display("FAIL t2_bypass: v=%b d0=%h want 1/aa", out_valid, out_data[0]);
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_pending();
      issue(8'h03, 2'b01, 2'b00, 6'd9, 6'd0);
      tick(); idle_inputs(); out_ready = 1;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin wr_valid[1] = 1; wr_rnid[1] = 6'd9; wr_data[1] = 64'h55; end
         #1;
         n_vec++; if (out_valid !== 1'b0 || o_ready !== 1'b0 || dbg_state !== RR_WAIT) begin
            n_err++; $display("FAIL t3_wait_c%0d: v=%b rdy=%b st=%0d want 0/0/WAIT", c, out_valid, o_ready, dbg_state);
         end
         out_ready = 0; tick(); out_ready = (c < 3);
         wr_valid = 0;
      end
      n_vec++; if (out_valid !== 1'b1 || out_data[0] !== 64'h55 || out_tag !== 8'h03) begin
         n_err++; $display("FAIL t3_out: v=%b d0=%h tag=%h want 1/55/03", out_valid, out_data[0], out_tag);
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_back_to_back();
      rf[3] = 64'h33; rf[6] = 64'h66;
      issue(8'h04, 2'b01, 2'b01, 6'd3, 6'd0);
      tick(); idle_inputs();
      rf[3] = 64'hDEAD;
      for (int c = 0; c < 4; c++) begin
         valid = c[0]; tag = 8'hEE;
         #1;
         n_vec++; if (out_valid !== 1'b1 || out_data[0] !== 64'h33 || out_tag !== 8'h04 || o_ready !== 1'b0) begin
            n_err++; $display("FAIL t4_hold_c%0d: v=%b d0=%h tag=%h rdy=%b want 1/33/04/0", c, out_valid, out_data[0], out_tag, o_ready);
         end
         tick();
      end
      out_ready = 1; issue(8'h05, 2'b01, 2'b01, 6'd6, 6'd0);
      #1;
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL t4_handoff_ready: got %b want 1", o_ready); end
      tick(); idle_inputs();
      n_vec++; if (out_valid !== 1'b1 || out_tag !== 8'h05 || out_data[0] !== 64'h66) begin
         n_err++; $display("FAIL t4_new: v=%b tag=%h d0=%h want 1/05/66", out_valid, out_tag, out_data[0]);
      end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_flush();
      issue(8'h06, 2'b01, 2'b00, 6'd12, 6'd0);
      tick(); idle_inputs();
      flush = 1; valid = 1; #1;
      n_vec++; if (o_ready !== 1'b0 || rd_valid !== 2'b00) begin
         n_err++; $display("FAIL t5_flush_block: rdy=%b rdv=%b want 0/00", o_ready, rd_valid);
      end
      tick(); idle_inputs();
      n_vec++; if (dbg_state !== RR_IDLE || out_valid !== 1'b0) begin
         n_err++; $display("FAIL t5_flush_idle: st=%0d v=%b want IDLE/0", dbg_state, out_valid);
      end
      wr_valid[0] = 1; wr_rnid[0] = 6'd12; wr_data[0] = 64'h12;
      tick(); idle_inputs(); tick();
      n_vec++; if (out_valid !== 1'b0 || dbg_state !== RR_IDLE) begin
         n_err++; $display("FAIL t5_after_write: v=%b st=%0d want 0/IDLE", out_valid, dbg_state);
      end
   endtask

   task automatic test_reset_mid_wait();
      rf[4] = 64'h44;
      issue(8'h07, 2'b11, 2'b10, 6'd13, 6'd4);
      tick(); idle_inputs(); #1;
      rst_n = 0; #1;
      n_vec++; if (out_valid !== 1'b0 || out_tag !== 8'h0 || out_data !== '0 || dbg_state !== RR_IDLE) begin
         n_err++; $display("FAIL t6_reset: v=%b tag=%h data=%h st=%0d want zeros/IDLE", out_valid, out_tag, out_data, dbg_state);
      end
      #3; rst_n = 1;
      tick();
      n_vec++; if (o_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL t6_release: rdy=%b v=%b want 1/0", o_ready, out_valid);
      end
   endtask

   // Reference: an entry is either empty, complete, or waiting on named registers;
   // a waiting source takes the first writeback to its register (lowest port on ties).
   task automatic find_write(input logic [5:0] r, output bit f, output logic [63:0] d);
      f = 0; d = 0;
      for (int p = 0; p < 5; p++)
         if (!f && wr_valid[p] && wr_rnid[p] == r && r != 0) begin f = 1; d = wr_data[p]; end
   endtask

   task automatic test_random();
      bit m_full = 0, f, acc, exp_rdy;
      bit m_pend [2] = '{0, 0};
      logic [5:0] m_rn [2];
      logic [63:0] m_val [2], d;
      logic [7:0] m_tag = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         valid = 1'($urandom_range(0, 1)); tag = 8'($urandom);
         used = 2'($urandom); rdy = 2'($urandom);
         for (int k = 0; k < 2; k++) rnid[k] = 6'($urandom_range(0, 15));
         for (int p = 0; p < 5; p++) begin
            wr_valid[p] = ($urandom_range(0, 3) == 0);
            wr_rnid[p] = 6'($urandom_range(0, 15));
            wr_data[p] = {$urandom, $urandom};
         end
         out_ready = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 19) == 0);
         #1;
         exp_rdy = !flush && ((!m_full && !(m_pend[0] || m_pend[1])) || (m_full && out_ready));
         acc = valid && exp_rdy;
         n_vec++; if (o_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, o_ready, exp_rdy); end
         for (int k = 0; k < 2; k++) begin
            n_vec++; if (rd_valid[k] !== (acc && used[k] && rdy[k]) || rd_rnid[k] !== ((acc && used[k] && rdy[k]) ? rnid[k] : 6'd0)) begin
               n_err++; $display("FAIL rnd_rdport%0d@%0d: v=%b rnid=%0d", k, cyc, rd_valid[k], rd_rnid[k]);
            end
         end
         if (flush) begin
            m_full = 0; m_pend = '{0, 0};
         end else if (acc) begin
            m_tag = tag;
            for (int k = 0; k < 2; k++) begin
               m_pend[k] = 0; m_rn[k] = rnid[k];
               find_write(rnid[k], f, d);
               if (!used[k] || rnid[k] == 0) m_val[k] = 0;
               else if (f) m_val[k] = d;
               else if (rdy[k]) m_val[k] = rf[rnid[k]];
               else m_pend[k] = 1;
            end
            m_full = !(m_pend[0] || m_pend[1]);
         end else if (m_pend[0] || m_pend[1]) begin
            for (int k = 0; k < 2; k++) if (m_pend[k]) begin
               find_write(m_rn[k], f, d);
               if (f) begin m_val[k] = d; m_pend[k] = 0; end
            end
            m_full = !(m_pend[0] || m_pend[1]);
         end else if (m_full && out_ready) begin
            m_full = 0;
         end
         tick();
         n_vec++; if (out_valid !== m_full) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, m_full); end
         if (m_full) begin
            n_vec++; if (out_tag !== m_tag || out_data[0] !== m_val[0] || out_data[1] !== m_val[1]) begin
               n_err++; $display("FAIL rnd_data@%0d: tag=%h d=%h/%h want %h %h/%h", cyc, out_tag, out_data[0], out_data[1], m_tag, m_val[0], m_val[1]);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_pending();
      test_back_to_back();
      test_flush();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
